// File: rtl/note_recorder_if.sv
// Bundles the keyboard-side event inputs and the playback/status outputs of note_recorder.
interface note_recorder_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          record_en;
  logic          play_start;
  logic          play_stop;
  logic          key_press;
  logic          key_release;
  logic [3:0]    note_in;
  logic [1:0]    octave_in;
  logic [3:0]    play_note;
  logic [1:0]    play_octave;
  logic          play_strobe;
  logic          play_valid;
  logic          recording;
  logic          playing;
  logic [CW-1:0] count;
  logic          full;

  modport master (
    output record_en, play_start, play_stop, key_press, key_release, note_in, octave_in,
    input  play_note, play_octave, play_strobe, play_valid, recording, playing, count, full
  );

  modport slave (
    input  record_en, play_start, play_stop, key_press, key_release, note_in, octave_in,
    output play_note, play_octave, play_strobe, play_valid, recording, playing, count, full
  );
endinterface

// File: rtl/note_recorder.sv
// Records keyboard note events with held durations into a small buffer and replays them.
// Define NOTE_RECORDER_LOOP_EN to make playback wrap to entry 0 until stopped.
module note_recorder #(
  parameter int TICK_DIV = 500000,
  parameter int DEPTH    = 16,
  parameter int DUR_W    = 8
) (
  input logic           clk,
  input logic           reset,
  note_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = 6 + DUR_W;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
  localparam logic [CW-1:0]    CNT_DEPTH = CW'(DEPTH);

`ifdef NOTE_RECORDER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    REC_IDLE,
    REC_HOLD,
    PLAY_LOAD,
    PLAY_HOLD
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    rd_entry;
  logic             record_en_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    ptr_q;
  logic [CW-1:0]    ptr_inc;
  logic [PW-1:0]    pre_q;
  logic [DUR_W-1:0] dur_q;
  logic [3:0]       note_q;
  logic [1:0]       octave_q;
  logic [3:0]       play_note_q;
  logic [1:0]       play_octave_q;
  logic             play_strobe_q;

  logic             tick_wrap;
  logic [DUR_W-1:0] dur_inc;
  logic [DUR_W-1:0] dur_wr;
  logic             is_full;
  logic             full_after_wr;
  logic             hold_done;
  logic             last_entry;

  logic wr_en;
  logic open_note;
  logic clear_count;
  logic start_play;
  logic load_entry;
  logic advance;

  assign tick_wrap     = (pre_q == PRE_LAST);
  assign is_full       = (count_q == CNT_DEPTH);
  assign full_after_wr = (count_q == CNT_DEPTH - CW'(1));
  assign ptr_inc       = ptr_q + CW'(1);
  assign last_entry    = (ptr_inc == count_q);
  assign hold_done     = tick_wrap && (dur_q <= DUR_ONE);
  assign rd_entry      = mem[ptr_q[AW-1:0]];

  // The cycle that sees the release still counts toward the held time.
  assign dur_inc = (tick_wrap && dur_q != DUR_MAX) ? dur_q + DUR_ONE : dur_q;
  assign dur_wr  = (dur_inc == '0) ? DUR_ONE : dur_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wr_en       = 1'b0;
    open_note   = 1'b0;
    clear_count = 1'b0;
    start_play  = 1'b0;
    load_entry  = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.record_en && !record_en_q) begin
          state_nx    = REC_IDLE;
          clear_count = 1'b1;
        end else if (bus.play_start && !bus.record_en && count_q != '0) begin
          state_nx   = PLAY_LOAD;
          start_play = 1'b1;
        end
      end
      REC_IDLE: begin
        if (!bus.record_en) begin
          state_nx = IDLE;
        end else if (bus.key_press && !is_full) begin
          state_nx  = REC_HOLD;
          open_note = 1'b1;
        end
      end
      REC_HOLD: begin
        if (!bus.record_en) begin
          wr_en    = 1'b1;
          state_nx = IDLE;
        end else if (bus.key_press) begin
          wr_en = 1'b1;
          if (!full_after_wr) begin
            open_note = 1'b1;
          end else begin
            state_nx = REC_IDLE;
          end
        end else if (bus.key_release) begin
          wr_en    = 1'b1;
          state_nx = REC_IDLE;
        end
      end
      PLAY_LOAD: begin
        if (bus.play_stop || (LOOP_EN && bus.record_en)) begin
          state_nx = IDLE;
        end else begin
          load_entry = 1'b1;
          state_nx   = PLAY_HOLD;
        end
      end
      PLAY_HOLD: begin
        if (bus.play_stop || (LOOP_EN && bus.record_en)) begin
          state_nx = IDLE;
        end else if (hold_done) begin
          advance  = 1'b1;
          state_nx = (last_entry && !LOOP_EN) ? IDLE : PLAY_LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[AW-1:0]] <= {note_q, octave_q, dur_wr};
    end
  end

  // The prescaler and duration counter are shared: they count up while recording
  // and count the remaining ticks down while an entry plays.
  always_ff @(posedge clk) begin
    if (reset) begin
      record_en_q   <= 1'b0;
      count_q       <= '0;
      ptr_q         <= '0;
      pre_q         <= '0;
      dur_q         <= '0;
      note_q        <= '0;
      octave_q      <= '0;
      play_note_q   <= '0;
      play_octave_q <= '0;
      play_strobe_q <= 1'b0;
    end else begin
      record_en_q   <= bus.record_en;
      play_strobe_q <= load_entry;

      if (clear_count) begin
        count_q <= '0;
      end else if (wr_en) begin
        count_q <= count_q + CW'(1);
      end

      if (open_note) begin
        note_q   <= bus.note_in;
        octave_q <= bus.octave_in;
        pre_q    <= '0;
        dur_q    <= '0;
      end else if (state == REC_HOLD) begin
        pre_q <= tick_wrap ? '0 : pre_q + PW'(1);
        dur_q <= dur_inc;
      end else if (load_entry) begin
        play_note_q   <= rd_entry[EW-1 -: 4];
        play_octave_q <= rd_entry[DUR_W+1 -: 2];
        dur_q         <= rd_entry[DUR_W-1:0];
        pre_q         <= '0;
      end else if (state == PLAY_HOLD) begin
        pre_q <= tick_wrap ? '0 : pre_q + PW'(1);
        if (tick_wrap) begin
          dur_q <= dur_q - DUR_ONE;
        end
      end

      if (start_play) begin
        ptr_q <= '0;
      end else if (advance) begin
        ptr_q <= last_entry ? '0 : ptr_inc;
      end
    end
  end

  assign bus.play_note   = play_note_q;
  assign bus.play_octave = play_octave_q;
  assign bus.play_strobe = play_strobe_q;
  assign bus.play_valid  = (state == PLAY_HOLD);
  assign bus.recording   = (state == REC_IDLE) || (state == REC_HOLD);
  assign bus.playing     = (state == PLAY_LOAD) || (state == PLAY_HOLD);
  assign bus.count       = count_q;
  assign bus.full        = is_full;
endmodule

// File: tb/tb_note_recorder.sv
// Randomized scoreboard bench for note_recorder; a monitor checks every replayed note
// against a list-of-notes model. Honours NOTE_RECORDER_LOOP_EN when defined.
module tb_note_recorder;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 16;
  localparam int DUR_W    = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  note_recorder_if #(.DEPTH(DEPTH)) bus ();

  note_recorder #(
    .TICK_DIV(TICK_DIV),
    .DEPTH   (DEPTH),
    .DUR_W   (DUR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] note;
    logic [1:0] octave;
    int         cycles;
    bit         check_len;
  } exp_t;

  typedef struct {
    logic [3:0] note;
    logic [1:0] octave;
    int         dur;
  } entry_t;

  exp_t   exp_q[$];
  entry_t model_buf[$];
  int     n_checks   = 0;
  int     n_pass     = 0;
  int     strobe_cnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int dur_of(input int cycles);
    int d;
    d = cycles / TICK_DIV;
    if (d > (1 << DUR_W) - 1) d = (1 << DUR_W) - 1;
    if (d < 1) d = 1;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected note per strobe and measures how long it sounds.
  int   len;
  int   gap;
  bit   in_note   = 1'b0;
  bit   have_prev = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (reset) begin
      in_note   = 1'b0;
      have_prev = 1'b0;
    end else if (bus.play_strobe) begin
      strobe_cnt++;
      checkOutput("strobe_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        checkOutput("play_note", int'(bus.play_note), int'(cur.note));
        checkOutput("play_octave", int'(bus.play_octave), int'(cur.octave));
        checkOutput("valid_with_strobe", int'(bus.play_valid), 1);
      end
      if (have_prev) checkOutput("gap_cycles", gap, 1);
      in_note   = 1'b1;
      have_prev = 1'b0;
      len       = 1;
    end else if (in_note) begin
      if (bus.play_valid) begin
        len++;
      end else begin
        in_note = 1'b0;
        if (cur.check_len) checkOutput("hold_cycles", len, cur.cycles);
        gap       = 1;
        have_prev = bus.playing;
      end
    end else if (bus.playing && !bus.play_valid) begin
      gap++;
    end else if (!bus.playing) begin
      have_prev = 1'b0;
    end
  end

  task automatic begin_record(input bit with_play_start);
    bus.record_en  = 1'b1;
    bus.play_start = with_play_start;
    step();
    bus.play_start = 1'b0;
    model_buf.delete();
    @(negedge clk);
    checkOutput("recording_on", int'(bus.recording), 1);
    checkOutput("count_cleared", int'(bus.count), 0);
    if (with_play_start) checkOutput("record_beats_play", int'(bus.playing), 0);
  endtask

  task automatic end_record();
    bus.record_en = 1'b0;
    step();
    @(negedge clk);
    checkOutput("recording_off", int'(bus.recording), 0);
  endtask

  // One press/hold/release; the model keeps the note only if the buffer had room.
  task automatic applyStimulus(input logic [3:0] note, input logic [1:0] octave, input int cycles);
    bit opened;
    opened = model_buf.size() < DEPTH;
    bus.note_in   = note;
    bus.octave_in = octave;
    bus.key_press = 1'b1;
    step();
    bus.key_press = 1'b0;
    repeat (cycles - 1) step();
    bus.key_release = 1'b1;
    step();
    bus.key_release = 1'b0;
    if (opened) model_buf.push_back('{note, octave, dur_of(cycles)});
    @(negedge clk);
    checkOutput("count_after_release", int'(bus.count), model_buf.size());
    checkOutput("full_flag", int'(bus.full), int'(model_buf.size() == DEPTH));
  endtask

  task automatic overlap_notes(input logic [3:0] n1, input logic [1:0] o1, input int h1,
                               input logic [3:0] n2, input logic [1:0] o2, input int h2);
    bit opened;
    bus.note_in   = n1;
    bus.octave_in = o1;
    bus.key_press = 1'b1;
    step();
    bus.key_press = 1'b0;
    repeat (h1 - 1) step();
    bus.note_in   = n2;
    bus.octave_in = o2;
    bus.key_press = 1'b1;
    step();
    bus.key_press = 1'b0;
    model_buf.push_back('{n1, o1, dur_of(h1)});
    opened = model_buf.size() < DEPTH;
    @(negedge clk);
    checkOutput("count_at_overlap", int'(bus.count), model_buf.size());
    checkOutput("still_holding", int'(bus.recording), 1);
    repeat (h2 - 1) step();
    bus.key_release = 1'b1;
    step();
    bus.key_release = 1'b0;
    if (opened) model_buf.push_back('{n2, o2, dur_of(h2)});
    @(negedge clk);
    checkOutput("count_after_overlap", int'(bus.count), model_buf.size());
  endtask

  task automatic play_model();
    int budget;
    int base;
    budget = 20;
    foreach (model_buf[i]) begin
      exp_q.push_back('{model_buf[i].note, model_buf[i].octave, model_buf[i].dur * TICK_DIV, 1'b1});
      budget += model_buf[i].dur * TICK_DIV + 1;
    end
`ifdef NOTE_RECORDER_LOOP_EN
    exp_q.push_back('{model_buf[0].note, model_buf[0].octave, 0, 1'b0});
    budget += model_buf[0].dur * TICK_DIV + 1;
`endif
    base = strobe_cnt;
    bus.play_start = 1'b1;
    step();
    bus.play_start = 1'b0;
`ifdef NOTE_RECORDER_LOOP_EN
    for (int i = 0; i < budget && strobe_cnt < base + model_buf.size() + 1; i++) step();
    checkOutput("loop_strobes", strobe_cnt - base, model_buf.size() + 1);
    bus.play_stop = 1'b1;
    step();
    bus.play_stop = 1'b0;
    @(negedge clk);
    checkOutput("loop_stopped", int'(bus.playing), 0);
`else
    for (int i = 0; i < budget && bus.playing; i++) step();
    @(negedge clk);
    checkOutput("play_done", int'(bus.playing), 0);
    checkOutput("strobe_count", strobe_cnt - base, model_buf.size());
`endif
    checkOutput("exp_drained", exp_q.size(), 0);
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    reset           = 1'b1;
    bus.record_en   = 1'b0;
    bus.play_start  = 1'b0;
    bus.play_stop   = 1'b0;
    bus.key_press   = 1'b0;
    bus.key_release = 1'b0;
    bus.note_in     = '0;
    bus.octave_in   = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_play_note", int'(bus.play_note), 0);
    checkOutput("rst_play_octave", int'(bus.play_octave), 0);
    checkOutput("rst_play_strobe", int'(bus.play_strobe), 0);
    checkOutput("rst_play_valid", int'(bus.play_valid), 0);
    checkOutput("rst_recording", int'(bus.recording), 0);
    checkOutput("rst_playing", int'(bus.playing), 0);
    checkOutput("rst_count", int'(bus.count), 0);
    checkOutput("rst_full", int'(bus.full), 0);
    step();

    $display("[TB] basic record/playback");
    begin_record(1'b0);
    applyStimulus(4'd3, 2'd1, 10);
    repeat (3) step();
    applyStimulus(4'd7, 2'd2, 20);
    end_record();
    play_model();

    $display("[TB] short press");
    begin_record(1'b0);
    applyStimulus(4'd9, 2'd3, 2);
    end_record();
    play_model();

    $display("[TB] overlapping press");
    begin_record(1'b0);
    overlap_notes(4'd2, 2'd1, 12, 4'd5, 2'd0, 9);
    end_record();
    play_model();

    $display("[TB] full buffer");
    begin_record(1'b1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom_range(4, 7));
      step();
    end
    end_record();
    play_model();

    $display("[TB] randomized phrases");
    for (int it = 0; it < 3; it++) begin
      begin_record(1'b0);
      for (int j = 0; j < int'($urandom_range(2, 5)); j++) begin
        applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom_range(1, 30));
        repeat ($urandom_range(0, 3)) step();
      end
      end_record();
      play_model();
    end

    $display("[TB] reset during a held note");
    bus.record_en = 1'b1;
    step();
    bus.note_in   = 4'd11;
    bus.octave_in = 2'd2;
    bus.key_press = 1'b1;
    step();
    bus.key_press = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    checkOutput("mid_rst_play_note", int'(bus.play_note), 0);
    checkOutput("mid_rst_play_octave", int'(bus.play_octave), 0);
    checkOutput("mid_rst_play_valid", int'(bus.play_valid), 0);
    checkOutput("mid_rst_recording", int'(bus.recording), 0);
    checkOutput("mid_rst_playing", int'(bus.playing), 0);
    checkOutput("mid_rst_count", int'(bus.count), 0);
    reset         = 1'b0;
    bus.record_en = 1'b0;
    step();

    $display("[TB] stop during playback");
    begin_record(1'b0);
    applyStimulus(4'd4, 2'd3, 16);
    end_record();
    exp_q.push_back('{4'd4, 2'd3, 0, 1'b0});
    base = strobe_cnt;
    bus.play_start = 1'b1;
    step();
    bus.play_start = 1'b0;
    for (int i = 0; i < 20 && strobe_cnt == base; i++) step();
    checkOutput("stop_strobe_seen", strobe_cnt - base, 1);
    bus.play_stop = 1'b1;
    step();
    bus.play_stop = 1'b0;
    @(negedge clk);
    checkOutput("stop_play_valid", int'(bus.play_valid), 0);
    checkOutput("stop_playing", int'(bus.playing), 0);
    checkOutput("stop_exp_drained", exp_q.size(), 0);

    $display("[TB] start with empty buffer");
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checkOutput("empty_count", int'(bus.count), 0);
    bus.play_start = 1'b1;
    step();
    bus.play_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("empty_start_playing", int'(bus.playing), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
